// File: rtl/dpram_pipe.sv
// Single-clock simple dual-port RAM with byte-lane writes, 1/2-cycle read latency,
// defined same-address collision behaviour and a post-reset zero-fill sequencer.
// Optional per-lane even parity: define DPRAM_PIPE_PARITY_EN.
module dpram_pipe #(
  parameter int ASZ        = 10,
  parameter int DSZ        = 16,
  parameter int BSZ        = 8,
  parameter int RD_LAT     = 1,
  parameter int WR_MODE    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ASZ-1:0]       wr_addr,
  input  logic [DSZ/BSZ-1:0]   wr_be,
  input  logic [DSZ-1:0]       data_in,
  input  logic                 rd_en,
  input  logic [ASZ-1:0]       rd_addr,
  output logic [DSZ-1:0]       data_out,
  output logic                 rd_valid,
  output logic                 init_busy
`ifdef DPRAM_PIPE_PARITY_EN
  ,
  input  logic                 par_inj,
  output logic                 parity_err
`endif
);

  localparam int NB    = DSZ / BSZ;
  localparam int DEPTH = 1 << ASZ;

  if ((DSZ % BSZ) != 0 || (RD_LAT != 1 && RD_LAT != 2)) begin : g_param_err
    $error("dpram_pipe: DSZ must be a multiple of BSZ and RD_LAT must be 1 or 2");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t         state, state_nxt;
  logic [ASZ-1:0] clr_addr, clr_addr_nxt;

  logic [DSZ-1:0] mem [DEPTH];
  logic [DSZ-1:0] be_mask;
  logic [DSZ-1:0] wr_word;
  logic [DSZ-1:0] rd_word;
  logic           wr_acc, rd_acc, bypass;

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (CLR_ON_RST != 0) ? CLEAR : READY;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    init_busy    = 1'b0;
    unique case (state)
      CLEAR: begin
        init_busy    = 1'b1;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == '1) state_nxt = READY;
      end
      READY: begin
        state_nxt = READY;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  assign wr_acc = wr_en && (state == READY);
  assign rd_acc = rd_en && (state == READY);
  assign bypass = (WR_MODE == 1) && wr_acc && (wr_addr == rd_addr);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign be_mask[g*BSZ +: BSZ] = {BSZ{wr_be[g]}};
  end

  assign wr_word = (mem[wr_addr] & ~be_mask) | (data_in & be_mask);

  // Write-through merges only the enabled lanes; disabled lanes still read memory.
  always_comb begin
    rd_word = mem[rd_addr];
    if (bypass) rd_word = (rd_word & ~be_mask) | (data_in & be_mask);
  end

`ifdef DPRAM_PIPE_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] din_par, word_par, rd_par;
  logic          rd_err;

  for (genvar g = 0; g < NB; g++) begin : g_par
    assign din_par[g]  = (^data_in[g*BSZ +: BSZ]) ^ par_inj;
    assign word_par[g] = ^rd_word[g*BSZ +: BSZ];
  end

  always_comb begin
    rd_par = par_mem[rd_addr];
    if (bypass) rd_par = (rd_par & ~wr_be) | (din_par & wr_be);
  end

  assign rd_err = |(rd_par ^ word_par);
`endif

  // Storage has no reset; the sequencer provides deterministic contents instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
`ifdef DPRAM_PIPE_PARITY_EN
      par_mem[clr_addr] <= '0;
`endif
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_word;
`ifdef DPRAM_PIPE_PARITY_EN
      par_mem[wr_addr] <= (par_mem[wr_addr] & ~wr_be) | (din_par & wr_be);
`endif
    end
  end

  // ---------------------------------------------------------------- read pipeline
  if (RD_LAT == 2) begin : g_lat2
    logic [DSZ-1:0] s1_data;
    logic           s1_valid;
`ifdef DPRAM_PIPE_PARITY_EN
    logic           s1_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        data_out <= '0;
        rd_valid <= 1'b0;
`ifdef DPRAM_PIPE_PARITY_EN
        s1_err     <= 1'b0;
        parity_err <= 1'b0;
`endif
      end else begin
        s1_valid <= rd_acc;
        rd_valid <= s1_valid;
        if (rd_acc) begin
          s1_data <= rd_word;
`ifdef DPRAM_PIPE_PARITY_EN
          s1_err  <= rd_err;
`endif
        end
        if (s1_valid) begin
          data_out <= s1_data;
`ifdef DPRAM_PIPE_PARITY_EN
          parity_err <= s1_err;
`endif
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out <= '0;
        rd_valid <= 1'b0;
`ifdef DPRAM_PIPE_PARITY_EN
        parity_err <= 1'b0;
`endif
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) begin
          data_out <= rd_word;
`ifdef DPRAM_PIPE_PARITY_EN
          parity_err <= rd_err;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dpram_pipe.sv
// Directed bench for dpram_pipe: four instances (latency 2 read-old, latency 2
// write-through, latency 1 read-old, latency 1 without clear) on shared inputs.
module tb_dpram_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] data_in = '0;
  logic [15:0] dout0, dout1, dout2, dout3;
  logic        valid0, valid1, valid2, valid3;
  logic        busy0, busy1, busy2, busy3;
`ifdef DPRAM_PIPE_PARITY_EN
  logic        par_inj = 1'b0;
  logic        perr0, perr1, perr2, perr3;
`endif

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  dpram_pipe #(.ASZ(4), .DSZ(16), .BSZ(8), .RD_LAT(2), .WR_MODE(0), .CLR_ON_RST(1)) d0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout0),
    .rd_valid(valid0), .init_busy(busy0)
`ifdef DPRAM_PIPE_PARITY_EN
    , .par_inj(par_inj), .parity_err(perr0)
`endif
  );

  dpram_pipe #(.ASZ(4), .DSZ(16), .BSZ(8), .RD_LAT(2), .WR_MODE(1), .CLR_ON_RST(1)) d1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout1),
    .rd_valid(valid1), .init_busy(busy1)
`ifdef DPRAM_PIPE_PARITY_EN
    , .par_inj(par_inj), .parity_err(perr1)
`endif
  );

  dpram_pipe #(.ASZ(4), .DSZ(16), .BSZ(8), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(1)) d2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout2),
    .rd_valid(valid2), .init_busy(busy2)
`ifdef DPRAM_PIPE_PARITY_EN
    , .par_inj(par_inj), .parity_err(perr2)
`endif
  );

  dpram_pipe #(.ASZ(4), .DSZ(16), .BSZ(8), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(0)) d3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout3),
    .rd_valid(valid3), .init_busy(busy3)
`ifdef DPRAM_PIPE_PARITY_EN
    , .par_inj(par_inj), .parity_err(perr3)
`endif
  );

  typedef struct {
    logic        wr;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        rd;
    logic [3:0]  ra;
    logic [15:0] e0;   // read-old result
    logic [15:0] e1;   // write-through result
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [3:0] wa, input logic [1:0] be,
                              input logic [15:0] wd, input logic rd, input logic [3:0] ra,
                              input logic [15:0] e0, input logic [15:0] e1, input string name);
    vec_t v;
    v.wr = wr; v.wa = wa; v.be = be; v.wd = wd;
    v.rd = rd; v.ra = ra; v.e0 = e0; v.e1 = e1; v.name = name;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One stimulus cycle; for reads, check both latencies and the hold cycle after.
  task automatic apply(input vec_t v);
    wr_en = v.wr; wr_addr = v.wa; wr_be = v.be; data_in = v.wd;
    rd_en = v.rd; rd_addr = v.ra;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    if (v.rd) begin
      chk({v.name, "_l1_valid"}, valid2, 1);
      chk({v.name, "_l1_data"},  dout2,  v.e0);
      chk({v.name, "_l2_early"}, valid0, 0);
      cyc();
      chk({v.name, "_l2_valid"},  valid0, 1);
      chk({v.name, "_l2_data"},   dout0,  v.e0);
      chk({v.name, "_wt_valid"},  valid1, 1);
      chk({v.name, "_wt_data"},   dout1,  v.e1);
      chk({v.name, "_l1_drop"},   valid2, 0);
      chk({v.name, "_l1_hold"},   dout2,  v.e0);
      cyc();
      chk({v.name, "_l2_drop"},   valid0, 0);
      chk({v.name, "_l2_hold"},   dout0,  v.e0);
    end
  endtask

  // Counts init_busy cycles from the current negedge; bounded.
  task automatic clear_window(input string nm);
    int unsigned n;
    int unsigned bad;
    n = 0; bad = 0;
    while (busy0 && n < 100) begin
      n++;
      cyc();
      if (valid0 || valid1 || valid2) bad++;
    end
    chk({nm, "_len"}, n, 16);
    chk({nm, "_rdvalid"}, bad, 0);
    chk({nm, "_busy_wt"}, busy1, 0);
    chk({nm, "_busy_l1"}, busy2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen3;

    vecs.push_back(mk(1, 3,  2'b11, 16'hBEEF, 0, 0,  16'h0000, 16'h0000, "wr3"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 3,  16'hBEEF, 16'hBEEF, "lat_rd3"));
    vecs.push_back(mk(1, 5,  2'b11, 16'h1234, 0, 0,  16'h0000, 16'h0000, "wr5"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 5,  16'h1234, 16'h1234, "rd5"));
    vecs.push_back(mk(1, 5,  2'b10, 16'hABCD, 0, 0,  16'h0000, 16'h0000, "wr5_hi"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 5,  16'hAB34, 16'hAB34, "be_hi"));
    vecs.push_back(mk(1, 5,  2'b00, 16'hFFFF, 0, 0,  16'h0000, 16'h0000, "wr5_none"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 5,  16'hAB34, 16'hAB34, "be_none"));
    vecs.push_back(mk(1, 5,  2'b01, 16'h5566, 0, 0,  16'h0000, 16'h0000, "wr5_lo"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 5,  16'hAB66, 16'hAB66, "be_lo"));
    vecs.push_back(mk(1, 7,  2'b11, 16'h1111, 0, 0,  16'h0000, 16'h0000, "wr7"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 7,  16'h1111, 16'h1111, "rd7"));
    vecs.push_back(mk(1, 7,  2'b11, 16'h2222, 1, 7,  16'h1111, 16'h2222, "coll_full"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 7,  16'h2222, 16'h2222, "coll_after"));
    vecs.push_back(mk(1, 7,  2'b01, 16'h3344, 1, 7,  16'h2222, 16'h2244, "coll_part"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 7,  16'h2244, 16'h2244, "coll_part_after"));
    vecs.push_back(mk(1, 8,  2'b11, 16'h9999, 1, 3,  16'hBEEF, 16'hBEEF, "diff_addr"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 8,  16'h9999, 16'h9999, "rd8"));
    vecs.push_back(mk(1, 15, 2'b11, 16'hCAFE, 0, 0,  16'h0000, 16'h0000, "wr15"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 15, 16'hCAFE, 16'hCAFE, "top_addr"));
    vecs.push_back(mk(0, 0,  2'b00, 16'h0000, 1, 0,  16'h0000, 16'h0000, "bottom_addr"));

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dout",   dout0,  0);
    chk("rst_valid",  valid0, 0);
    chk("rst_dout_l1", dout2, 0);
    chk("rst_busy",   busy0,  1);
    chk("rst_busy_l1", busy2, 1);
    chk("rst_busy_noclr", busy3, 0);
    @(negedge clk);
    @(negedge clk);

    // Release with a write and read pending: both must be ignored during clear
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_be = 2'b11; data_in = 16'hFFFF;
    rd_en = 1'b1; rd_addr = 4'd2;
    clear_window("clr1");
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    cyc();
    chk("clr1_post_valid", valid0, 0);

    // Every address reads zero after the clear (address 2 included)
    for (int unsigned a = 0; a < 16; a++)
      apply(mk(0, 0, 2'b00, 16'h0000, 1, 4'(a), 16'h0000, 16'h0000, $sformatf("clr_rd%0d", a)));

    foreach (vecs[i]) apply(vecs[i]);

    // Back-to-back reads: continuous rd_valid
    rd_en = 1'b1; rd_addr = 4'd3;
    cyc();
    chk("b2b_l1_v1", valid2, 1); chk("b2b_l1_d1", dout2, 16'hBEEF);
    chk("b2b_noclr_v1", valid3, 1); chk("b2b_noclr_d1", dout3, 16'hBEEF);
    rd_addr = 4'd5;
    cyc();
    chk("b2b_l1_v2", valid2, 1); chk("b2b_l1_d2", dout2, 16'hAB66);
    chk("b2b_l2_v1", valid0, 1); chk("b2b_l2_d1", dout0, 16'hBEEF);
    rd_addr = 4'd7;
    cyc();
    chk("b2b_l1_v3", valid2, 1); chk("b2b_l1_d3", dout2, 16'h2244);
    chk("b2b_l2_v2", valid0, 1); chk("b2b_l2_d2", dout0, 16'hAB66);
    rd_en = 1'b0;
    cyc();
    chk("b2b_l1_end", valid2, 0);
    chk("b2b_l2_v3", valid0, 1); chk("b2b_l2_d3", dout0, 16'h2244);
    cyc();
    chk("b2b_l2_end", valid0, 0);

`ifdef DPRAM_PIPE_PARITY_EN
    wr_en = 1'b1; wr_addr = 4'd4; wr_be = 2'b01; data_in = 16'h00FF; par_inj = 1'b1;
    cyc();
    wr_en = 1'b0; par_inj = 1'b0; wr_be = '0;
    rd_en = 1'b1; rd_addr = 4'd4;
    cyc();
    rd_en = 1'b0;
    chk("par_inj_l1_v", valid2, 1); chk("par_inj_l1", perr2, 1); chk("par_inj_noclr", perr3, 1);
    cyc();
    chk("par_inj_l2", perr0, 1); chk("par_inj_wt", perr1, 1);
    wr_en = 1'b1; wr_be = 2'b01; data_in = 16'h00FF;
    cyc();
    wr_en = 1'b0; wr_be = '0;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("par_ok_l1", perr2, 0);
    cyc();
    chk("par_ok_l2", perr0, 0);
`endif

    // Reset during an in-flight read
    rd_en = 1'b1; rd_addr = 4'd15;
    @(posedge clk);
    #1;
    chk("inflight_l1_pre", dout2, 16'hCAFE);
    rd_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_inflight_dout_l2", dout0, 0);
    chk("rst_inflight_valid_l2", valid0, 0);
    chk("rst_inflight_dout_l1", dout2, 0);
    chk("rst_inflight_valid_l1", valid2, 0);
    chk("rst_inflight_busy", busy0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset again at clear address 9
    repeat (9) cyc();
    chk("mid_clr_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_clr_rst_busy", busy0, 1);
    chk("mid_clr_rst_valid", valid0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen3 = busy3;
    chk("mid_clr_noclr_busy", seen3, 0);
    clear_window("clr2");
    cyc();

    apply(mk(0, 0, 2'b00, 16'h0000, 1, 15, 16'h0000, 16'h0000, "reclr_rd15"));
    apply(mk(0, 0, 2'b00, 16'h0000, 1, 9,  16'h0000, 16'h0000, "reclr_rd9"));
    apply(mk(0, 0, 2'b00, 16'h0000, 1, 3,  16'h0000, 16'h0000, "reclr_rd3"));
`ifdef DPRAM_PIPE_PARITY_EN
    apply(mk(0, 0, 2'b00, 16'h0000, 1, 4,  16'h0000, 16'h0000, "reclr_rd4"));
    chk("reclr_par", perr0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
